negedge_order_sorter: RTL and testbench

NEGEDGE_ORDER_SORTER -- requirements
Module: negedge_order_sorter

---
 rtl/negedge_order_sorter_if.sv | 31 +++
 rtl/negedge_order_sorter.sv | 164 ++++++++++++++++
 tb/tb_negedge_order_sorter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/negedge_order_sorter_if.sv
// Result-stream handshake for negedge_order_sorter: one beat per line,
// carrying the line index, its captured time and an end-of-run flag.
interface negedge_order_sorter_if #(
  parameter int NUM_INPUTS = 8,
  parameter int MAX_VALUE  = 8
);
  localparam int IW = $clog2(NUM_INPUTS);
  localparam int TW = $clog2(MAX_VALUE + 1);

  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [TW-1:0] out_time;
  logic          out_last;

  modport master (
    output out_valid,
    output out_index,
    output out_time,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    input  out_time,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/negedge_order_sorter.sv
// Timestamps falling event lines inside a capture window, then streams them out by time.
// Define NEGEDGE_SORTER_EMIT_UNFIRED_EN to also stream unfired lines with time 0.
module negedge_order_sorter #(
  parameter int NUM_INPUTS = 8,
  parameter int MAX_VALUE  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [NUM_INPUTS-1:0] incoming_lines,
  output logic                  busy,
  output logic                  done,
  negedge_order_sorter_if.master out
);
  localparam int IW = $clog2(NUM_INPUTS);
  localparam int TW = $clog2(MAX_VALUE + 1);
  localparam logic [TW-1:0] MAXV = TW'(MAX_VALUE);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    EMIT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [TW-1:0]         elapsed;
  logic [NUM_INPUTS-1:0] captured;
  logic [NUM_INPUTS-1:0] emitted;
  logic [TW-1:0]         stamp [NUM_INPUTS];

  logic [NUM_INPUTS-1:0] fall;
  logic [NUM_INPUTS-1:0] cap_nxt;
  logic [NUM_INPUTS-1:0] pending;
  logic                  cap_end;
  logic                  sel_found;
  logic                  sel_last;
  logic [IW-1:0]         sel_idx;
  logic [TW-1:0]         sel_time;
  logic                  xfer;

  assign fall    = ~incoming_lines & ~captured;
  assign cap_nxt = captured | fall;
  assign cap_end = (&cap_nxt) || (elapsed == MAXV);

  // Winner: largest stamp, first index wins ties.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_time  = '0;
    pending   = captured & ~emitted;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (captured[i] && !emitted[i] &&
          (!sel_found || stamp[i] > sel_time)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        sel_time  = stamp[i];
      end
    end
`ifdef NEGEDGE_SORTER_EMIT_UNFIRED_EN
    pending = ~emitted;
    if (!sel_found) begin
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        if (!emitted[i]) begin
          sel_idx  = IW'(i);
          sel_time = '0;
        end
      end
    end
`endif
  end

  // Exactly one pending bit means this beat is the final one.
  assign sel_last = (pending != '0) &&
    ((pending & (pending - NUM_INPUTS'(1))) == '0);

  assign xfer = (state == EMIT) && out.out_ready;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (cap_end) begin
`ifdef NEGEDGE_SORTER_EMIT_UNFIRED_EN
          state_nxt = EMIT;
`else
          state_nxt = (|cap_nxt) ? EMIT : DONE;
`endif
        end
      end
      EMIT: begin
        if (xfer && sel_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out.out_valid = (state == EMIT);
    out.out_index = '0;
    out.out_time  = '0;
    out.out_last  = 1'b0;
    if (state == EMIT) begin
      out.out_index = sel_idx;
      out.out_time  = sel_time;
      out.out_last  = sel_last;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      elapsed  <= '0;
      captured <= '0;
      emitted  <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        stamp[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            elapsed  <= '0;
            captured <= '0;
            emitted  <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
              stamp[i] <= '0;
            end
          end
        end
        CAPTURE: begin
          captured <= cap_nxt;
          if (!cap_end) elapsed <= elapsed + TW'(1);
          for (int i = 0; i < NUM_INPUTS; i++) begin
            if (fall[i]) stamp[i] <= MAXV - elapsed;
          end
        end
        EMIT: begin
          if (xfer) emitted[sel_idx] <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_negedge_order_sorter.sv
// Bench for negedge_order_sorter: vector table, reset corners and
// randomized runs against a time-bucket reference model.
module tb_negedge_order_sorter;
  localparam int N     = 4;
  localparam int M     = 8;
  localparam int NEVER = 99;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] incoming_lines = '1;
  logic         busy;
  logic         done;

  negedge_order_sorter_if #(.NUM_INPUTS(N), .MAX_VALUE(M)) bus ();

  negedge_order_sorter #(.NUM_INPUTS(N), .MAX_VALUE(M)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .incoming_lines (incoming_lines),
    .busy           (busy),
    .done           (done),
    .out            (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0][7:0] fk;
    logic [N-1:0][7:0] bi;
    logic [N-1:0][7:0] bt;
    logic [7:0]        stall;
    logic              rs;
    logic [7:0]        n;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input int f0, f1, f2, f3, input int stall, input bit rs, input int n,
    input int i0, t0, i1, t1, i2, t2, i3, t3);
    vec_t v;
    v.fk    = {8'(f3), 8'(f2), 8'(f1), 8'(f0)};
    v.bi    = {8'(i3), 8'(i2), 8'(i1), 8'(i0)};
    v.bt    = {8'(t3), 8'(t2), 8'(t1), 8'(t0)};
    v.stall = 8'(stall);
    v.rs    = rs;
    v.n     = 8'(n);
    return v;
  endfunction

  function automatic logic line_val(input int f, input bit p, input int k);
    if (f > M) return 1'b1;
    if (k == f) return 1'b0;
    if (k > f && !p) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_unfired(input int fk[N], inout int en,
                             inout int ei[N], inout int et[N]);
`ifdef NEGEDGE_SORTER_EMIT_UNFIRED_EN
    for (int i = 0; i < N; i++) begin
      if (fk[i] > M) begin
        ei[en] = i;
        et[en] = 0;
        en++;
      end
    end
`endif
  endtask

  // Reference: time = M - fall cycle; walk time buckets high to low.
  task automatic model(input int fk[N], output int en, output int ei[N],
                       output int et[N], output int ncap);
    bit all_f = 1'b1;
    int mx = 0;
    en = 0;
    for (int i = 0; i < N; i++) begin
      ei[i] = 0;
      et[i] = 0;
      if (fk[i] > M) all_f = 1'b0;
      else if (fk[i] > mx) mx = fk[i];
    end
    ncap = all_f ? mx + 1 : M + 1;
    for (int t = M; t >= 0; t--) begin
      for (int i = 0; i < N; i++) begin
        if (fk[i] <= M && M - fk[i] == t) begin
          ei[en] = i;
          et[en] = t;
          en++;
        end
      end
    end
    add_unfired(fk, en, ei, et);
  endtask

  task automatic run(input string tag, input int fk[N], input bit pl[N],
                     input int rmode, input int stall, input bit restart,
                     input int en, input int ei[N], input int et[N],
                     input int ncap);
    int  got = 0;
    int  done_c = -1;
    int  last_c = -1;
    int  first_v = -1;
    int  nvalid = 0;
    bit  hold = 1'b0;
    bit  rdy;
    int  h_idx = 0;
    int  h_tm = 0;
    int  h_last = 0;
    int  bi[N];
    int  bt[N];
    int  bl[N];
    @(negedge clock);
    start = 1'b1;
    incoming_lines = '1;
    bus.out_ready = 1'b0;
    for (int c = 1; c < 100 && done_c < 0; c++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        nvalid++;
        if (first_v < 0) first_v = c;
        if (hold) begin
          chk({tag, "_stall_idx"}, int'(bus.out_index), h_idx);
          chk({tag, "_stall_time"}, int'(bus.out_time), h_tm);
          chk({tag, "_stall_last"}, int'(bus.out_last), h_last);
        end
      end
      if (done) done_c = c;
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (nvalid > stall);
      endcase
      if (bus.out_valid && rdy) begin
        if (got < N) begin
          bi[got] = int'(bus.out_index);
          bt[got] = int'(bus.out_time);
          bl[got] = int'(bus.out_last);
        end
        got++;
        last_c = c;
      end
      hold   = bus.out_valid && !rdy;
      h_idx  = int'(bus.out_index);
      h_tm   = int'(bus.out_time);
      h_last = int'(bus.out_last);
      bus.out_ready = rdy;
      start = restart && (c == 3 || done_c == c);
      for (int i = 0; i < N; i++) begin
        incoming_lines[i] = line_val(fk[i], pl[i], c - 1);
      end
    end
    if (done_c < 0) chk({tag, "_timeout"}, 0, 1);
    @(negedge clock);
    start = 1'b0;
    bus.out_ready = 1'b0;
    incoming_lines = '1;
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_done"}, int'(done), 0);
    chk({tag, "_beats"}, got, en);
    for (int j = 0; j < en && j < got && j < N; j++) begin
      chk($sformatf("%s_b%0d_idx", tag, j), bi[j], ei[j]);
      chk($sformatf("%s_b%0d_time", tag, j), bt[j], et[j]);
      chk($sformatf("%s_b%0d_last", tag, j), bl[j], int'(j == en - 1));
    end
    chk({tag, "_first_valid"}, first_v, en > 0 ? ncap + 1 : -1);
    chk({tag, "_done_cycle"}, done_c, en > 0 ? last_c + 1 : ncap + 1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int fk[N];
    bit pl[N];
    int ei[N];
    int et[N];
    int mi[N];
    int mt[N];
    int en;
    int mn;
    int ncap;
    for (int i = 0; i < N; i++) begin
      fk[i] = int'(v.fk[i]);
      pl[i] = 1'b0;
      ei[i] = int'(v.bi[i]);
      et[i] = int'(v.bt[i]);
    end
    en = int'(v.n);
    add_unfired(fk, en, ei, et);
    model(fk, mn, mi, mt, ncap);
    run(tag, fk, pl, v.stall > 0 ? 2 : 0, int'(v.stall), v.rs,
        en, ei, et, ncap);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_last"}, int'(bus.out_last), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_idx"}, int'(bus.out_index), 0);
    chk({tag, "_time"}, int'(bus.out_time), 0);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    tbl[0] = mkv(3, 5, 1, 3, 0, 1, 4, 2, 7, 0, 5, 3, 5, 1, 3);
    tbl[1] = mkv(0, 0, 0, 0, 0, 0, 4, 0, 8, 1, 8, 2, 8, 3, 8);
    tbl[2] = mkv(NEVER, 8, NEVER, NEVER, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[3] = mkv(NEVER, NEVER, NEVER, NEVER, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mkv(2, 2, NEVER, 0, 0, 1, 3, 3, 8, 0, 6, 1, 6, 0, 0);
    tbl[5] = mkv(8, 7, 8, 6, 2, 0, 4, 3, 2, 1, 1, 0, 0, 2, 0);

    #1;
    check_reset_outputs("por");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      run_vec($sformatf("vec%0d", t), tbl[t]);
    end

    // Reset in the middle of EMIT after one beat has gone out.
    @(negedge clock);
    start = 1'b1;
    incoming_lines = '1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    incoming_lines = '0;
    @(negedge clock);
    chk("rst_emit_v0", int'(bus.out_valid), 1);
    @(negedge clock);
    chk("rst_emit_idx1", int'(bus.out_index), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_emit");
    @(negedge clock);
    reset_n = 1'b1;
    incoming_lines = '1;
    @(negedge clock);
    chk("rst_emit_post_valid", int'(bus.out_valid), 0);
    chk("rst_emit_post_busy", int'(busy), 0);
    run_vec("fresh", tbl[0]);

    // Reset in the middle of CAPTURE.
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("rst_cap_busy_pre", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_cap");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_cap_post_busy", int'(busy), 0);

    for (int r = 0; r < 40; r++) begin
      int fk[N];
      bit pl[N];
      int ei[N];
      int et[N];
      int en;
      int ncap;
      for (int i = 0; i < N; i++) begin
        fk[i] = int'($urandom_range(0, 11));
        pl[i] = 1'($urandom_range(0, 1));
      end
      model(fk, en, ei, et, ncap);
      run($sformatf("rnd%0d", r), fk, pl, 1, 0, 1'($urandom_range(0, 1)),
          en, ei, et, ncap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
